// File: rtl/register_rename.sv
// Rename/dispatch stage: allocates ROB tags, maintains the RAT and ARF, registers renamed ops.
// Optional RENAME_STATS_EN adds stat_renamed / stat_stall counters.
module register_rename #(
  parameter int unsigned NUM_ARCH_REGS = 32,
  parameter int unsigned TAG_WIDTH     = 6,
  parameter int unsigned DATA_WIDTH    = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  dec_valid,
  output logic                  dec_ready,
  input  logic [4:0]            dec_rs1,
  input  logic [4:0]            dec_rs2,
  input  logic [4:0]            dec_rd,
  input  logic [31:0]           dec_pc,
  input  logic                  rob_full,
  output logic                  rob_alloc_valid,
  output logic [4:0]            rob_alloc_rd,
  output logic [31:0]           rob_alloc_pc,
  input  logic [TAG_WIDTH-1:0]  rob_alloc_tag,
  input  logic                  rob_alloc_ack,
  input  logic                  cdb_valid,
  input  logic [TAG_WIDTH-1:0]  cdb_tag,
  input  logic [DATA_WIDTH-1:0] cdb_data,
  input  logic                  commit_valid,
  input  logic [4:0]            commit_rd,
  input  logic [DATA_WIDTH-1:0] commit_data,
  input  logic [TAG_WIDTH-1:0]  commit_tag,
  output logic                  ren_valid,
  input  logic                  ren_ready,
  output logic [TAG_WIDTH-1:0]  ren_tag,
  output logic [4:0]            ren_rd,
  output logic [31:0]           ren_pc,
  output logic                  ren_src1_ready,
  output logic [TAG_WIDTH-1:0]  ren_src1_tag,
  output logic [DATA_WIDTH-1:0] ren_src1_value,
  output logic                  ren_src2_ready,
  output logic [TAG_WIDTH-1:0]  ren_src2_tag,
  output logic [DATA_WIDTH-1:0] ren_src2_value
`ifdef RENAME_STATS_EN
  ,
  output logic [31:0]           stat_renamed,
  output logic [31:0]           stat_stall
`endif
);

  typedef struct packed {
    logic                  ready;
    logic [TAG_WIDTH-1:0]  tag;
    logic [DATA_WIDTH-1:0] value;
  } src_t;

  logic                  busy_q [NUM_ARCH_REGS];
  logic                  done_q [NUM_ARCH_REGS];
  logic [TAG_WIDTH-1:0]  tag_q  [NUM_ARCH_REGS];
  logic [DATA_WIDTH-1:0] val_q  [NUM_ARCH_REGS];
  logic [DATA_WIDTH-1:0] arf_q  [NUM_ARCH_REGS];

  logic slot_free;
  logic fire;
  src_t src1;
  src_t src2;

  // Source resolution against the pre-update RAT, with CDB and commit bypasses.
  function automatic src_t lookup(input logic [4:0]            rs,
                                  input logic                  busy,
                                  input logic                  done,
                                  input logic [TAG_WIDTH-1:0]  tag,
                                  input logic [DATA_WIDTH-1:0] val,
                                  input logic [DATA_WIDTH-1:0] arf_val,
                                  input logic                  c_valid,
                                  input logic [TAG_WIDTH-1:0]  c_tag,
                                  input logic [DATA_WIDTH-1:0] c_data,
                                  input logic                  m_valid,
                                  input logic [4:0]            m_rd,
                                  input logic [DATA_WIDTH-1:0] m_data);
    src_t s;
    s = '0;
    if (rs == 5'd0) begin
      s.ready = 1'b1;
    end else if (busy && done) begin
      s.ready = 1'b1;
      s.value = val;
    end else if (busy && c_valid && (c_tag == tag)) begin
      s.ready = 1'b1;
      s.value = c_data;
    end else if (busy) begin
      s.tag = tag;
    end else if (m_valid && (m_rd == rs)) begin
      s.ready = 1'b1;
      s.value = m_data;
    end else begin
      s.ready = 1'b1;
      s.value = arf_val;
    end
    return s;
  endfunction

  always_comb begin
    slot_free       = !ren_valid || ren_ready;
    dec_ready       = !rst && slot_free && !rob_full;
    rob_alloc_valid = dec_valid && dec_ready;
    rob_alloc_rd    = dec_rd;
    rob_alloc_pc    = dec_pc;
    fire            = rob_alloc_valid && rob_alloc_ack;
    src1 = lookup(dec_rs1, busy_q[dec_rs1], done_q[dec_rs1], tag_q[dec_rs1], val_q[dec_rs1],
                  arf_q[dec_rs1], cdb_valid, cdb_tag, cdb_data, commit_valid, commit_rd,
                  commit_data);
    src2 = lookup(dec_rs2, busy_q[dec_rs2], done_q[dec_rs2], tag_q[dec_rs2], val_q[dec_rs2],
                  arf_q[dec_rs2], cdb_valid, cdb_tag, cdb_data, commit_valid, commit_rd,
                  commit_data);
  end

  // RAT and ARF; later assignments win, so fire overrides commit and CDB on the same rd.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int r = 0; r < NUM_ARCH_REGS; r++) begin
        busy_q[r] <= 1'b0;
        done_q[r] <= 1'b0;
        tag_q[r]  <= '0;
        val_q[r]  <= '0;
        arf_q[r]  <= '0;
      end
    end else begin
      for (int r = 1; r < NUM_ARCH_REGS; r++) begin
        if (cdb_valid && busy_q[r] && !done_q[r] && (tag_q[r] == cdb_tag)) begin
          done_q[r] <= 1'b1;
          val_q[r]  <= cdb_data;
        end
        if (commit_valid && (commit_rd == 5'(r))) begin
          arf_q[r] <= commit_data;
          if (busy_q[r] && (tag_q[r] == commit_tag)) begin
            busy_q[r] <= 1'b0;
            done_q[r] <= 1'b0;
          end
        end
        if (fire && (dec_rd == 5'(r))) begin
          busy_q[r] <= 1'b1;
          tag_q[r]  <= rob_alloc_tag;
          done_q[r] <= 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ren_valid      <= 1'b0;
      ren_tag        <= '0;
      ren_rd         <= '0;
      ren_pc         <= '0;
      ren_src1_ready <= 1'b0;
      ren_src1_tag   <= '0;
      ren_src1_value <= '0;
      ren_src2_ready <= 1'b0;
      ren_src2_tag   <= '0;
      ren_src2_value <= '0;
    end else if (fire) begin
      ren_valid      <= 1'b1;
      ren_tag        <= rob_alloc_tag;
      ren_rd         <= dec_rd;
      ren_pc         <= dec_pc;
      ren_src1_ready <= src1.ready;
      ren_src1_tag   <= src1.tag;
      ren_src1_value <= src1.value;
      ren_src2_ready <= src2.ready;
      ren_src2_tag   <= src2.tag;
      ren_src2_value <= src2.value;
    end else if (ren_ready) begin
      ren_valid <= 1'b0;
    end else begin
      // Held op: wake waiting sources from the CDB so no broadcast is lost.
      if (cdb_valid && !ren_src1_ready && (ren_src1_tag == cdb_tag)) begin
        ren_src1_ready <= 1'b1;
        ren_src1_value <= cdb_data;
      end
      if (cdb_valid && !ren_src2_ready && (ren_src2_tag == cdb_tag)) begin
        ren_src2_ready <= 1'b1;
        ren_src2_value <= cdb_data;
      end
    end
  end

`ifdef RENAME_STATS_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stat_renamed <= '0;
      stat_stall   <= '0;
    end else begin
      if (fire) stat_renamed <= stat_renamed + 32'd1;
      if (dec_valid && !dec_ready) stat_stall <= stat_stall + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_register_rename.sv
// Randomized bench for register_rename: the bench plays decoder, ROB and consumer, and predicts
// outputs from a tag-indexed result table and a per-register mapping model.
module tb_register_rename;

  logic        clk = 1'b0;
  logic        rst;
  logic        dec_valid, dec_ready;
  logic [4:0]  dec_rs1, dec_rs2, dec_rd;
  logic [31:0] dec_pc;
  logic        rob_full, rob_alloc_valid, rob_alloc_ack;
  logic [4:0]  rob_alloc_rd;
  logic [31:0] rob_alloc_pc;
  logic [5:0]  rob_alloc_tag;
  logic        cdb_valid;
  logic [5:0]  cdb_tag;
  logic [31:0] cdb_data;
  logic        commit_valid;
  logic [4:0]  commit_rd;
  logic [31:0] commit_data;
  logic [5:0]  commit_tag;
  logic        ren_valid, ren_ready;
  logic [5:0]  ren_tag;
  logic [4:0]  ren_rd;
  logic [31:0] ren_pc;
  logic        ren_src1_ready, ren_src2_ready;
  logic [5:0]  ren_src1_tag, ren_src2_tag;
  logic [31:0] ren_src1_value, ren_src2_value;
`ifdef RENAME_STATS_EN
  logic [31:0] stat_renamed, stat_stall;
`endif

  register_rename dut (
    .clk(clk), .rst(rst),
    .dec_valid(dec_valid), .dec_ready(dec_ready), .dec_rs1(dec_rs1), .dec_rs2(dec_rs2),
    .dec_rd(dec_rd), .dec_pc(dec_pc), .rob_full(rob_full),
    .rob_alloc_valid(rob_alloc_valid), .rob_alloc_rd(rob_alloc_rd), .rob_alloc_pc(rob_alloc_pc),
    .rob_alloc_tag(rob_alloc_tag), .rob_alloc_ack(rob_alloc_ack),
    .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_data(cdb_data),
    .commit_valid(commit_valid), .commit_rd(commit_rd), .commit_data(commit_data),
    .commit_tag(commit_tag),
    .ren_valid(ren_valid), .ren_ready(ren_ready), .ren_tag(ren_tag), .ren_rd(ren_rd),
    .ren_pc(ren_pc),
    .ren_src1_ready(ren_src1_ready), .ren_src1_tag(ren_src1_tag),
    .ren_src1_value(ren_src1_value),
    .ren_src2_ready(ren_src2_ready), .ren_src2_tag(ren_src2_tag),
    .ren_src2_value(ren_src2_value)
`ifdef RENAME_STATS_EN
    , .stat_renamed(stat_renamed), .stat_stall(stat_stall)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  typedef struct packed {
    logic        r;
    logic [5:0]  t;
    logic [31:0] v;
  } src_t;

  typedef struct {
    logic [5:0]  tag;
    logic [4:0]  rd;
    bit          done;
    logic [31:0] val;
  } rob_e;

  // Reference state: which tag each register waits on, and results known per tag.
  bit          m_mapped [32];
  logic [5:0]  m_map    [32];
  logic [31:0] m_arf    [32];
  bit          res_known[64];
  logic [31:0] res_val  [64];
  rob_e        rob_q[$];
  logic [5:0]  tail;
  int          n_ren, n_stall;

  // Expected content of the output register.
  logic        e_valid;
  logic [5:0]  e_tag;
  logic [4:0]  e_rd;
  logic [31:0] e_pc;
  src_t        e_s1, e_s2;

  task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 32; i++) begin
      m_mapped[i] = 0;
      m_map[i] = '0;
      m_arf[i] = '0;
    end
    for (int i = 0; i < 64; i++) begin
      res_known[i] = 0;
      res_val[i] = '0;
    end
    rob_q.delete();
    tail = '0;
    e_valid = 0;
    n_ren = 0;
    n_stall = 0;
  endtask

  function automatic src_t lookup(input logic [4:0] rs);
    src_t s;
    s = '0;
    if (rs == 0) begin
      s.r = 1;
    end else if (m_mapped[rs]) begin
      s.t = m_map[rs];
      if (res_known[s.t]) begin
        s.r = 1;
        s.v = res_val[s.t];
      end else if (cdb_valid && cdb_tag == s.t) begin
        s.r = 1;
        s.v = cdb_data;
      end
    end else if (commit_valid && commit_rd == rs) begin
      s.r = 1;
      s.v = commit_data;
    end else begin
      s.r = 1;
      s.v = m_arf[rs];
    end
    return s;
  endfunction

  task automatic chk_outputs();
    chk("ren_valid", 64'(ren_valid), 64'(e_valid));
    if (e_valid) begin
      chk("ren_tag", 64'(ren_tag), 64'(e_tag));
      chk("ren_rd", 64'(ren_rd), 64'(e_rd));
      chk("ren_pc", 64'(ren_pc), 64'(e_pc));
      chk("src1_ready", 64'(ren_src1_ready), 64'(e_s1.r));
      if (e_s1.r) chk("src1_value", 64'(ren_src1_value), 64'(e_s1.v));
      else        chk("src1_tag", 64'(ren_src1_tag), 64'(e_s1.t));
      chk("src2_ready", 64'(ren_src2_ready), 64'(e_s2.r));
      if (e_s2.r) chk("src2_value", 64'(ren_src2_value), 64'(e_s2.v));
      else        chk("src2_tag", 64'(ren_src2_tag), 64'(e_s2.t));
    end
`ifdef RENAME_STATS_EN
    chk("stat_renamed", 64'(stat_renamed), 64'(n_ren));
    chk("stat_stall", 64'(stat_stall), 64'(n_stall));
`endif
  endtask

  task automatic step();
    int   cand[$];
    int   cdb_idx;
    bit   exp_rdy, fire;
    src_t s1, s2;
    @(negedge clk);
    chk_outputs();
    dec_valid = ($urandom_range(0, 3) != 0);
    dec_rs1   = 5'($urandom_range(0, 7));
    dec_rs2   = 5'($urandom_range(0, 7));
    dec_rd    = 5'($urandom_range(0, 7));
    dec_pc    = $urandom;
    rob_full  = (rob_q.size() >= 8) || ($urandom_range(0, 7) == 0);
    rob_alloc_tag = tail;
    rob_alloc_ack = ($urandom_range(0, 7) != 0);
    ren_ready = ($urandom_range(0, 2) != 0);
    cdb_valid = 0;
    cdb_tag   = 6'($urandom);
    cdb_data  = $urandom;
    cdb_idx   = -1;
    foreach (rob_q[i]) if (!rob_q[i].done) cand.push_back(i);
    if (cand.size() > 0 && $urandom_range(0, 1) == 1) begin
      cdb_idx   = cand[$urandom_range(0, cand.size() - 1)];
      cdb_valid = 1;
      cdb_tag   = rob_q[cdb_idx].tag;
    end
    commit_valid = 0;
    commit_rd    = 5'($urandom);
    commit_data  = $urandom;
    commit_tag   = 6'($urandom);
    if (rob_q.size() > 0 && rob_q[0].done && $urandom_range(0, 1) == 1) begin
      commit_valid = 1;
      commit_rd    = rob_q[0].rd;
      commit_data  = rob_q[0].val;
      commit_tag   = rob_q[0].tag;
    end
    #1;
    exp_rdy = (!e_valid || ren_ready) && !rob_full;
    fire    = dec_valid && exp_rdy && rob_alloc_ack;
    chk("dec_ready", 64'(dec_ready), 64'(exp_rdy));
    chk("rob_alloc_valid", 64'(rob_alloc_valid), 64'(dec_valid && exp_rdy));
    if (dec_valid && exp_rdy) begin
      chk("rob_alloc_rd", 64'(rob_alloc_rd), 64'(dec_rd));
      chk("rob_alloc_pc", 64'(rob_alloc_pc), 64'(dec_pc));
    end
    s1 = lookup(dec_rs1);
    s2 = lookup(dec_rs2);
    if (fire) begin
      e_valid = 1;
      e_tag = tail;
      e_rd = dec_rd;
      e_pc = dec_pc;
      e_s1 = s1;
      e_s2 = s2;
    end else if (e_valid && ren_ready) begin
      e_valid = 0;
    end else if (e_valid && cdb_valid) begin
      if (!e_s1.r && e_s1.t == cdb_tag) begin e_s1.r = 1; e_s1.v = cdb_data; end
      if (!e_s2.r && e_s2.t == cdb_tag) begin e_s2.r = 1; e_s2.v = cdb_data; end
    end
    if (cdb_valid) begin
      res_known[cdb_tag] = 1;
      res_val[cdb_tag] = cdb_data;
      rob_q[cdb_idx].done = 1;
      rob_q[cdb_idx].val = cdb_data;
    end
    if (commit_valid) begin
      if (commit_rd != 0) begin
        m_arf[commit_rd] = commit_data;
        if (m_mapped[commit_rd] && m_map[commit_rd] == commit_tag) m_mapped[commit_rd] = 0;
      end
      void'(rob_q.pop_front());
    end
    if (fire) begin
      if (dec_rd != 0) begin
        m_mapped[dec_rd] = 1;
        m_map[dec_rd] = tail;
      end
      res_known[tail] = 0;
      rob_q.push_back('{tag: tail, rd: dec_rd, done: 0, val: '0});
      tail = tail + 6'd1;
      n_ren++;
    end
    if (dec_valid && !exp_rdy) n_stall++;
  endtask

  initial begin
    rst = 1;
    dec_valid = 1; dec_rs1 = 0; dec_rs2 = 0; dec_rd = 3; dec_pc = 32'h100;
    rob_full = 0; rob_alloc_tag = 0; rob_alloc_ack = 1;
    cdb_valid = 0; cdb_tag = 0; cdb_data = 0;
    commit_valid = 0; commit_rd = 0; commit_data = 0; commit_tag = 0;
    ren_ready = 1;
    model_reset();
    repeat (2) @(negedge clk);
    chk("rst_ren_valid", 64'(ren_valid), 64'd0);
    chk("rst_ren_tag", 64'(ren_tag), 64'd0);
    chk("rst_ren_pc", 64'(ren_pc), 64'd0);
    chk("rst_src1_value", 64'(ren_src1_value), 64'd0);
    chk("rst_dec_ready", 64'(dec_ready), 64'd0);
    chk("rst_alloc_valid", 64'(rob_alloc_valid), 64'd0);
    rst = 0;
    dec_valid = 0;

    repeat (3000) step();

    // Reset while an op is held in the output register.
    @(negedge clk);
    dec_valid = 1; dec_rs1 = 0; dec_rs2 = 0; dec_rd = 5; dec_pc = 32'h200;
    rob_full = 0; rob_alloc_ack = 1; ren_ready = 1; cdb_valid = 0; commit_valid = 0;
    rob_alloc_tag = tail;
    #1;
    chk("pre_rst_dec_ready", 64'(dec_ready), 64'd1);
    @(negedge clk);
    ren_ready = 0;
    chk("pre_rst_ren_valid", 64'(ren_valid), 64'd1);
    rst = 1;
    #1;
    chk("mid_rst_ren_valid", 64'(ren_valid), 64'd0);
    chk("mid_rst_dec_ready", 64'(dec_ready), 64'd0);
    chk("mid_rst_alloc_valid", 64'(rob_alloc_valid), 64'd0);
    @(negedge clk);
    rst = 0;
    model_reset();
    dec_valid = 1; dec_rs1 = 5; dec_rs2 = 0; dec_rd = 0; dec_pc = 32'h300;
    rob_alloc_tag = 0; ren_ready = 1;
    #1;
    chk("post_rst_alloc_valid", 64'(rob_alloc_valid), 64'd1);
    @(negedge clk);
    dec_valid = 0;
    chk("post_rst_ren_valid", 64'(ren_valid), 64'd1);
    chk("post_rst_src1_ready", 64'(ren_src1_ready), 64'd1);
    chk("post_rst_src1_value", 64'(ren_src1_value), 64'd0);
    chk("post_rst_ren_pc", 64'(ren_pc), 64'h300);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
